// File: rtl/axi_stream_arb_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiters.
// The round-robin search is written once here so later arbiters reuse the same priority rule.
package axi_stream_arb_pkg;

  localparam int CNT_W   = 16;
  localparam int MAX_NUM = 16;

  typedef enum logic {IDLE, XFER} arb_state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Search num entries starting just after last; the first set request wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_NUM-1:0] req,
                                       input logic [3:0]         last,
                                       input int                 num);
    rr_pick_t r;
    int       c;
    r = '0;
    for (int k = 1; k <= MAX_NUM; k++) begin
      c = (int'(last) + k) % num;
      if (k <= num && !r.found && req[c]) begin
        r.found = 1'b1;
        r.idx   = 4'(c);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_stream_packet_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotate requests, find the first set bit, then map it back to a source index.
module rr_priority_pick #(
  parameter int NUM    = 4,
  parameter int IDSIZE = 2
) (
  input  logic [NUM-1:0]    req,
  input  logic [IDSIZE-1:0] last,
  output logic [IDSIZE-1:0] pick,
  output logic              found
);

  logic [2*NUM-1:0] req_dbl;
  logic [NUM-1:0]   rot;
  int               start;

  always_comb begin
    start   = (int'(last) + 1) % NUM;
    req_dbl = {req, req} >> start;
    rot     = req_dbl[NUM-1:0];
    found   = |rot;
    pick    = '0;
    // Descending scan so the lowest rotated position (highest priority) wins.
    for (int k = NUM - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick = IDSIZE'((start + k) % NUM);
      end
    end
  end

endmodule

// File: rtl/axi_stream_packet_rr_arbiter.sv
// Packet-level round-robin arbiter: one source owns the downstream stream from first beat to tlast.
// Outputs are combinational from the registered grant; beats are counted and over-long packets flagged.
module axi_stream_packet_rr_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter int NUM       = 4,
  parameter int DSIZE     = 24,
  parameter int IDSIZE    = (NUM > 1) ? $clog2(NUM) : 1,
  parameter int MAX_BEATS = 16384
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM-1:0]       s_tvalid,
  input  logic [NUM*DSIZE-1:0] s_tdata,
  input  logic [NUM-1:0]       s_tlast,
  output logic [NUM-1:0]       s_tready,
  output logic                 m_tvalid,
  output logic [DSIZE-1:0]     m_tdata,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [IDSIZE-1:0]    m_tdest,
  output logic [CNT_W-1:0]     m_tcnt,
  output logic                 busy,
  output logic                 overlong_err
);

  arb_state_e        state_reg, state_next;
  logic [IDSIZE-1:0] grant_reg, grant_next;
  logic [IDSIZE-1:0] last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [DSIZE-1:0]  src_data [NUM];
  logic [IDSIZE-1:0] pick;
  logic              pick_found;
  logic              xfer;
  logic              hs;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
    assign src_data[gi] = s_tdata[gi*DSIZE +: DSIZE];
  end

  rr_priority_pick #(
    .NUM    (NUM),
    .IDSIZE (IDSIZE)
  ) u_pick (
    .req   (s_tvalid),
    .last  (last_grant_reg),
    .pick  (pick),
    .found (pick_found)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IDSIZE'(NUM - 1);
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
    end
  end

  always_comb begin
    xfer     = (state_reg == XFER);
    m_tvalid = xfer && s_tvalid[grant_reg];
    m_tlast  = xfer && s_tlast[grant_reg];
    m_tdata  = xfer ? src_data[grant_reg] : '0;
    s_tready = '0;
    if (xfer) begin
      s_tready[grant_reg] = m_tready;
    end
    hs           = m_tvalid && m_tready;
    // The counter passes MAX_BEATS-1 only once per packet, so this is a single pulse.
    overlong_err = hs && !m_tlast && (cnt_reg == CNT_W'(MAX_BEATS - 1));
    m_tdest      = grant_reg;
    m_tcnt       = cnt_reg;
    busy         = xfer;
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick;
          state_next = XFER;
        end
      end
      XFER: begin
        if (hs) begin
          if (m_tlast) begin
            last_grant_next = grant_reg;
            cnt_next        = '0;
            state_next      = IDLE;
          end else if (cnt_reg != '1) begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_stream_packet_rr_arbiter.sv
// Directed bench for the packet round-robin arbiter; sources emit beats tagged {source, packet no, beat no}.
module tb_axi_stream_packet_rr_arbiter;

  localparam int NUM   = 4;
  localparam int DSIZE = 24;

  logic              aclk;
  logic              aresetn;
  logic [NUM-1:0]    s_tvalid;
  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM-1:0]    s_tlast;
  logic [NUM-1:0]    s_tready;
  logic              m_tvalid;
  logic [DSIZE-1:0]  m_tdata;
  logic              m_tlast;
  logic              m_tready;
  logic [1:0]        m_tdest;
  logic [15:0]       m_tcnt;
  logic              busy;
  logic              overlong_err;

  int tests_run;
  int tests_failed;

  logic [NUM-1:0] src_en;
  int len  [NUM];
  int bcnt [NUM];
  int pkt  [NUM];

  axi_stream_packet_rr_arbiter #(
    .NUM       (NUM),
    .DSIZE     (DSIZE),
    .MAX_BEATS (8)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_tvalid     (s_tvalid),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tvalid     (m_tvalid),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .m_tdest      (m_tdest),
    .m_tcnt       (m_tcnt),
    .busy         (busy),
    .overlong_err (overlong_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Source model: valid follows src_en, tlast marks the final beat of a len-beat packet.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      s_tvalid[i]              = src_en[i];
      s_tlast[i]               = (bcnt[i] == len[i] - 1);
      s_tdata[i*DSIZE +: DSIZE] = {4'(i), 4'(pkt[i]), 16'(bcnt[i])};
    end
  end

  function automatic logic [23:0] dat(input int s, input int p, input int k);
    return {4'(s), 4'(p), 16'(k)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_beat(input string tag, input logic v, input int dest, input int cnt,
                          input logic [23:0] d, input logic last, input logic [3:0] rdy,
                          input logic bsy, input logic ovf);
    check({tag, ".tvalid"}, 32'(m_tvalid), 32'(v));
    check({tag, ".tdest"}, 32'(m_tdest), 32'(dest));
    check({tag, ".tcnt"}, 32'(m_tcnt), 32'(cnt));
    check({tag, ".tdata"}, 32'(m_tdata), 32'(d));
    check({tag, ".tlast"}, 32'(m_tlast), 32'(last));
    check({tag, ".s_tready"}, 32'(s_tready), 32'(rdy));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".overlong"}, 32'(overlong_err), 32'(ovf));
  endtask

  task automatic exp_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, ".s_tready"}, 32'(s_tready), 32'd0);
    check({tag, ".tdata"}, 32'(m_tdata), 32'd0);
    check({tag, ".tlast"}, 32'(m_tlast), 32'd0);
    check({tag, ".tcnt"}, 32'(m_tcnt), 32'd0);
    check({tag, ".overlong"}, 32'(overlong_err), 32'd0);
  endtask

  task automatic clear_model();
    src_en = '0;
    for (int i = 0; i < NUM; i++) begin
      len[i]  = 1;
      bcnt[i] = 0;
      pkt[i]  = 0;
    end
  endtask

  // Advance one clock: sample handshakes before the edge, update sources after it, return at negedge.
  task automatic tick();
    logic [NUM-1:0] hs;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready)
      $display("[TB] beat tdest=%0d tcnt=%0d tdata=%06h tlast=%0b overlong=%0b",
               m_tdest, m_tcnt, m_tdata, m_tlast, overlong_err);
    @(posedge aclk);
    #1;
    for (int i = 0; i < NUM; i++) begin
      if (hs[i]) begin
        if (bcnt[i] == len[i] - 1) begin
          bcnt[i] = 0;
          pkt[i]  = pkt[i] + 1;
        end else begin
          bcnt[i] = bcnt[i] + 1;
        end
      end
    end
    @(negedge aclk);
  endtask

  task automatic reset_dut();
    aresetn  = 1'b0;
    m_tready = 1'b0;
    clear_model();
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    aresetn      = 1'b0;
    m_tready     = 1'b0;
    clear_model();
    #1;
    exp_beat("rst", 0, 0, 0, 24'h0, 0, 4'b0000, 0, 0);
    reset_dut();

    // Single 3-beat packet from source 2.
    len[2]   = 3;
    src_en   = 4'b0100;
    m_tready = 1'b1;
    #1 exp_idle("t1_idle");
    tick();
    for (int k = 0; k < 3; k++) begin
      #1 exp_beat("t1_beat", 1, 2, k, dat(2, 0, k), k == 2, 4'b0100, 1, 0);
      tick();
    end
    src_en = '0;
    #1 exp_idle("t1_done");
    tick();

    // All sources requesting, 2-beat packets: grant order 0,1,2,3,0,1.
    reset_dut();
    for (int i = 0; i < NUM; i++) len[i] = 2;
    src_en   = 4'hf;
    m_tready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      #1 exp_idle("t2_idle");
      tick();
      for (int k = 0; k < 2; k++) begin
        #1 exp_beat("t2_beat", 1, p % 4, k, dat(p % 4, p / 4, k), k == 1,
                    4'(1 << (p % 4)), 1, 0);
        tick();
      end
    end
    src_en = '0;
    #1 exp_idle("t2_done");
    tick();

    // Backpressure on a 4-beat packet from source 1 (its third packet).
    len[1] = 4;
    src_en = 4'b0010;
    #1 exp_idle("t3_idle");
    tick();
    begin
      int k;
      int c;
      k = 0;
      c = 0;
      while (k < 4 && c < 20) begin
        m_tready = (c % 2 == 0);
        #1 exp_beat("t3_bp", 1, 1, k, dat(1, 2, k), k == 3,
                    m_tready ? 4'b0010 : 4'b0000, 1, 0);
        if (m_tready) k++;
        tick();
        c++;
      end
      check("t3_beats", 32'(k), 32'd4);
    end
    src_en   = '0;
    m_tready = 1'b1;
    #1 exp_idle("t3_done");
    tick();

    // Source 0 stalls for 5 cycles after beat 1 while source 3 requests.
    len[0] = 3;
    len[3] = 1;
    src_en = 4'b0001;
    #1 exp_idle("t4_idle");
    tick();
    for (int k = 0; k < 2; k++) begin
      #1 exp_beat("t4_beat", 1, 0, k, dat(0, 2, k), 0, 4'b0001, 1, 0);
      tick();
    end
    src_en = 4'b1000;
    for (int g = 0; g < 5; g++) begin
      #1 exp_beat("t4_gap", 0, 0, 2, dat(0, 2, 2), 1, 4'b0001, 1, 0);
      tick();
    end
    src_en = 4'b1001;
    #1 exp_beat("t4_last", 1, 0, 2, dat(0, 2, 2), 1, 4'b0001, 1, 0);
    tick();
    #1 exp_idle("t4_arb");
    tick();
    src_en = 4'b1000;
    #1 exp_beat("t4_s3", 1, 3, 0, dat(3, 1, 0), 1, 4'b1000, 1, 0);
    tick();
    src_en = '0;
    #1 exp_idle("t4_done");
    tick();

    // 10-beat packet with MAX_BEATS=8: overlong pulse on the beat with tcnt=7.
    len[2] = 10;
    src_en = 4'b0100;
    #1 exp_idle("t5_idle");
    tick();
    for (int k = 0; k < 10; k++) begin
      #1 exp_beat("t5_beat", 1, 2, k, dat(2, 1, k), k == 9, 4'b0100, 1, k == 7);
      tick();
    end
    src_en = '0;
    #1 exp_idle("t5_done");
    tick();

    // Asynchronous reset during beat 2, then source 0 regains top priority.
    len[1] = 4;
    src_en = 4'b0010;
    #1 exp_idle("t6_idle");
    tick();
    for (int k = 0; k < 3; k++) begin
      #1 exp_beat("t6_beat", 1, 1, k, dat(1, 3, k), 0, 4'b0010, 1, 0);
      if (k < 2) tick();
    end
    #1 aresetn = 1'b0;
    #1 exp_beat("t6_async", 0, 0, 0, 24'h0, 0, 4'b0000, 0, 0);
    clear_model();
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < NUM; i++) len[i] = 1;
    src_en = 4'hf;
    #1 exp_idle("t6_rearb");
    tick();
    src_en = 4'b0001;
    #1 exp_beat("t6_prio", 1, 0, 0, dat(0, 0, 0), 1, 4'b0001, 1, 0);
    tick();
    src_en = '0;
    #1 exp_idle("t6_done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_stream_packet_rr_arbiter.md
Name: axi_stream_packet_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one downstream AXI-stream packet datapath (packet FIFO, framer, DMA) among NUM upstream packet sources.
- Grant is held for a whole packet (tvalid to tlast), so packets are never interleaved.
- Each output packet is tagged with its source index and a per-beat counter.
- Over-long packets are flagged but not truncated.

Parameters:
- NUM, 4, number of requesting sources (2..16).
- DSIZE, 24, tdata width.
- IDSIZE, $clog2(NUM) (min 1), width of the source index.
- MAX_BEATS, 16384, beat limit per packet for overlong_err (1..65535).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_tvalid  in  NUM  per-source valid
- s_tdata  in  NUM*DSIZE  per-source data; source i occupies bits [i*DSIZE +: DSIZE]
- s_tlast  in  NUM  per-source last
- s_tready  out  NUM  per-source ready
- m_tvalid  out  1  output valid
- m_tdata  out  DSIZE  output data
- m_tlast  out  1  output last
- m_tready  in  1  downstream ready
- m_tdest  out  IDSIZE  index of the granted source
- m_tcnt  out  16  beat index within the current packet, starting at 0
- busy  out  1  high while in XFER
- overlong_err  out  1  one-cycle pulse when a packet reaches MAX_BEATS beats without tlast

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE, grant=0, last_grant=NUM-1, m_tcnt=0, busy=0, overlong_err=0. All s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tdest=0.
- Handshake:
  - A beat transfers when m_tvalid && m_tready.
  - All outputs are combinational from the registered grant: m_tvalid = XFER && s_tvalid[grant].
  - s_tready[grant] = XFER && m_tready; all other s_tready bits are 0.
  - m_tdata, m_tlast are muxed from the granted source; m_tdest = grant.
  - In IDLE, every s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0.
- State machine, two states:
  - IDLE: if any s_tvalid, register grant = first set index searching last_grant+1, last_grant+2, ... modulo NUM, then go to XFER. Otherwise stay.
  - XFER: on a handshake with m_tlast, set last_grant=grant and m_tcnt=0, then return to IDLE. On a handshake without tlast, m_tcnt += 1 (saturates at 65535). Otherwise hold.
- Latency and throughput:
  - One arbitration cycle. The first beat of a packet can transfer earliest in the cycle after the IDLE cycle that sees a request.
  - There is a one-cycle bubble between consecutive packets.
  - Peak throughput is L/(L+1) for L-beat packets.
- Fairness: after reset, source 0 has highest priority. A source that just finished a packet has lowest priority in the next arbitration. With all sources requesting, the grant order is 0,1,2,...,NUM-1,0.
- Grant is locked for the whole packet:
  - Deassertion of s_tvalid[grant] mid-packet stalls the output with m_tvalid=0. The grant is kept; no timeout.
  - Requests from other sources are ignored until tlast.
- overlong_err: pulses for one cycle on the handshake whose pre-increment m_tcnt == MAX_BEATS-1 and m_tlast=0. It pulses once per packet; transfer continues unchanged.
- Single-beat packet (tvalid and tlast on the first beat): one XFER cycle with m_tcnt=0, then IDLE.
- Backpressure: while m_tready=0, s_tready=0. The source holds its data per the AXI-stream rule.
- Reset mid-packet: returns immediately to the reset values. No partial-packet recovery; the downstream FIFO is reset in the same domain.
- s_tvalid/tlast bits of non-granted sources have no effect during XFER.

Decomposition:
- Package axi_stream_arb_pkg holds:
  - enum arb_state_e {IDLE, XFER};
  - function rr_pick(req, last) returning index and a found flag, shared with future arbiters;
  - localparam CNT_W=16.
- One sub-module: rr_priority_pick. Purely combinational rotate / find-first-set / rotate-back of width NUM, used in IDLE.
- The FSM, counter and muxing stay in the top module.

Test Plan:
- Reset then single request: s_tvalid[2]=1 with a 3-beat packet (A,B,C, tlast on C), m_tready=1.
  - IDLE for one cycle.
  - XFER beats on the next 3 cycles with m_tdest=2, m_tcnt=0,1,2 and m_tlast only on C.
  - busy=1 for 3 cycles, then IDLE.
- All 4 sources continuously valid, 2-beat packets: grant order is 0,1,2,3,0,1. Each packet takes 3 cycles (1 idle + 2 beats); there are no interleaved beats.
- Backpressure: a 4-beat packet from source 1 with m_tready toggled 1,0,1,0,...
  - s_tready[1] mirrors m_tready; data is never duplicated or dropped.
  - m_tcnt advances only on handshakes.
- Mid-packet gap: source 0 drops tvalid for 5 cycles after beat 1 while source 3 requests.
  - m_tvalid=0 for those 5 cycles and grant stays 0.
  - Source 3 is granted only after source 0's tlast.
- Overlong with MAX_BEATS=8: a 10-beat packet gives overlong_err high exactly on the handshake with m_tcnt=7. All 10 beats are delivered and tlast is on beat 9.
- Asynchronous reset asserted during beat 2 of a packet: all outputs go to reset values at once with no clock edge. After release, source 0 has top priority again.
